// File: rtl/puf_pkg.sv
// Shared definitions for the PUF evaluation scheduler: default widths, wait limit
// and the scheduler state encoding.
package puf_pkg;

    localparam int PUF_IN_WIDTH  = 128;
    localparam int PUF_OUT_WIDTH = 16;
    localparam int PUF_REPS_W    = 4;
    localparam int PUF_TIMEOUT   = 63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_REPORT
    } puf_state_t;

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit ones counters for the repeated PUF evaluations, with a combinational
// majority vote and a not-unanimous flag taken against the number of completed runs.
module puf_vote_acc
    import puf_pkg::*;
#(
    parameter int OUT_WIDTH = PUF_OUT_WIDTH,
    parameter int REPS_W    = PUF_REPS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_accEn,
    input  logic [OUT_WIDTH-1:0] i_bits,
    input  logic [REPS_W-1:0]    i_total,
    output logic [OUT_WIDTH-1:0] o_response,
    output logic [OUT_WIDTH-1:0] o_unstable
);

    logic [REPS_W-1:0] r_cnt [OUT_WIDTH];

    // A counter never exceeds the repeat count, so REPS_W bits cannot wrap.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            for (int i = 0; i < OUT_WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_accEn) begin
            for (int i = 0; i < OUT_WIDTH; i++) begin
                r_cnt[i] <= r_cnt[i] + REPS_W'(i_bits[i]);
            end
        end
    end

    // Vote compare at REPS_W+1 bits: 2*cnt > total, so an even tie resolves to 0.
    always_comb begin
        o_response = '0;
        o_unstable = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            o_response[i] = ({r_cnt[i], 1'b0} > {1'b0, i_total});
            o_unstable[i] = (r_cnt[i] != '0) && (r_cnt[i] != i_total);
        end
    end

endmodule

// File: rtl/puf_eval_scheduler.sv
// Runs one challenge through the PUF mapping block a requested number of times,
// majority-votes the responses and aborts with a mapping reset if done never comes.
module puf_eval_scheduler
    import puf_pkg::*;
#(
    parameter int IN_WIDTH  = PUF_IN_WIDTH,
    parameter int OUT_WIDTH = PUF_OUT_WIDTH,
    parameter int REPS_W    = PUF_REPS_W,
    parameter int TIMEOUT   = PUF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IN_WIDTH-1:0]  challenge,
    input  logic [REPS_W-1:0]    reps,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OUT_WIDTH-1:0] response,
    output logic [OUT_WIDTH-1:0] unstable,
    output logic                 timeout,
    output logic                 puf_trigger,
    output logic [IN_WIDTH-1:0]  puf_challenge,
    output logic                 puf_reset,
    input  logic                 puf_done,
    input  logic [OUT_WIDTH-1:0] puf_response
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    puf_state_t          r_state;
    logic [IN_WIDTH-1:0] r_challenge;
    logic [REPS_W-1:0]   r_reps;
    logic [REPS_W-1:0]   r_doneCnt;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_busy;
    logic                r_valid;
    logic                r_timeout;
    logic                r_trigger;
    logic                r_pufReset;

    logic w_accept;
    logic w_accEn;

    assign w_accept = (r_state == ST_IDLE) && start && (reps != '0);
    assign w_accEn  = (r_state == ST_WAIT) && puf_done;

    // Outputs are set on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_challenge <= '0;
            r_reps      <= '0;
            r_doneCnt   <= '0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_trigger   <= 1'b0;
            r_pufReset  <= 1'b0;
        end else begin
            r_trigger  <= 1'b0;
            r_pufReset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_challenge <= challenge;
                        r_reps      <= reps;
                        r_doneCnt   <= '0;
                        r_busy      <= 1'b1;
                        r_trigger   <= 1'b1;
                        r_state     <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_timer <= r_timer + TIMER_W'(1);
                    if (puf_done) begin
                        r_doneCnt <= r_doneCnt + REPS_W'(1);
                        if (r_doneCnt + REPS_W'(1) == r_reps) begin
                            r_valid <= 1'b1;
                            r_state <= ST_REPORT;
                        end else begin
                            r_trigger <= 1'b1;
                            r_state   <= ST_TRIG;
                        end
                    end else if (r_timer == TIMER_W'(TIMEOUT)) begin
                        r_timeout  <= 1'b1;
                        r_pufReset <= 1'b1;
                        r_valid    <= 1'b1;
                        r_state    <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (result_ready) begin
                        r_valid   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Voting against completed evaluations covers both normal and aborted runs.
    puf_vote_acc #(
        .OUT_WIDTH(OUT_WIDTH),
        .REPS_W   (REPS_W)
    ) u_voteAcc (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_accEn   (w_accEn),
        .i_bits    (puf_response),
        .i_total   (r_doneCnt),
        .o_response(response),
        .o_unstable(unstable)
    );

    assign busy          = r_busy;
    assign result_valid  = r_valid;
    assign timeout       = r_timeout;
    assign puf_trigger   = r_trigger;
    assign puf_reset     = r_pufReset;
    assign puf_challenge = r_challenge;

endmodule

// File: tb/tb_puf_eval_scheduler.sv
// Randomized self-checking bench for puf_eval_scheduler with a behavioural mapping
// block and a majority-vote reference computed from the responses it handed out.
module tb_puf_eval_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] challenge;
    logic [3:0]   reps;
    logic         busy;
    logic         result_valid;
    logic         result_ready;
    logic [15:0]  response;
    logic [15:0]  unstable;
    logic         timeout;
    logic         puf_trigger;
    logic [127:0] puf_challenge;
    logic         puf_reset;
    logic         puf_done;
    logic [15:0]  puf_response;

    int compared = 0;
    int mismatched = 0;

    // Mapping-block model configuration (written by the stimulus process only)
    int          caseNum = 0;
    int          modelLat = 4;
    int          doneLimit = 99;
    bit          spurious = 1'b0;
    logic [15:0] respList [16];

    // Mapping-block model state (written by the model process only)
    int seenCase = 0;
    int cd = 0;
    int respIdx = 0;
    int trigCount = 0;
    int resetPulses = 0;

    always #5 clk = ~clk;

    puf_eval_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .challenge    (challenge),
        .reps         (reps),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .response     (response),
        .unstable     (unstable),
        .timeout      (timeout),
        .puf_trigger  (puf_trigger),
        .puf_challenge(puf_challenge),
        .puf_reset    (puf_reset),
        .puf_done     (puf_done),
        .puf_response (puf_response)
    );

    // Mapping block: done arrives modelLat cycles after the trigger cycle, one cycle wide.
    always @(negedge clk) begin
        if (caseNum != seenCase) begin
            seenCase  = caseNum;
            cd        = 0;
            respIdx   = 0;
            trigCount = 0;
        end
        puf_done     = 1'b0;
        puf_response = 16'($urandom);
        if (puf_reset) resetPulses++;
        if (reset || puf_reset) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    puf_done     = 1'b1;
                    puf_response = respList[respIdx];
                    respIdx++;
                end
            end
            if (puf_trigger) begin
                trigCount++;
                if (trigCount <= doneLimit) cd = modelLat;
            end
        end
        if (spurious) begin
            puf_done     = 1'b1;
            puf_response = 16'($urandom);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void refVote(input int n, output logic [15:0] r, output logic [15:0] u);
        int ones;
        r = '0;
        u = '0;
        for (int b = 0; b < 16; b++) begin
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(respList[k][b]);
            r[b] = (2 * ones > n);
            u[b] = (ones != 0) && (ones != n);
        end
    endfunction

    task automatic applyStimulus(input int nReps, input int lat, input int limit,
                                 input int hold, input bit pokeStart);
        int           n;
        int           cycles;
        int           expTrig;
        int           rpBase;
        bit           expTo;
        logic [15:0]  expResp;
        logic [15:0]  expUnst;
        logic [127:0] expChal;

        expTo   = (limit < nReps);
        n       = expTo ? limit : nReps;
        expTrig = expTo ? limit + 1 : nReps;
        refVote(n, expResp, expUnst);
        expChal = {$urandom, $urandom, $urandom, $urandom};

        caseNum++;
        modelLat  = lat;
        doneLimit = limit;
        @(negedge clk);
        rpBase    = resetPulses;
        start     = 1'b1;
        challenge = expChal;
        reps      = 4'(nReps);
        @(negedge clk);
        start     = 1'b0;
        challenge = {$urandom, $urandom, $urandom, $urandom};
        reps      = 4'($urandom);
        checkOutput("busyAfterStart", 32'(busy), 32'd1);

        cycles = 0;
        while (!result_valid && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("resultValid", 32'(result_valid), 32'd1);
        checkOutput("response", 32'(response), 32'(expResp));
        checkOutput("unstable", 32'(unstable), 32'(expUnst));
        checkOutput("timeout", 32'(timeout), 32'(expTo));
        checkOutput("triggers", 32'(trigCount), 32'(expTrig));
        checkOutput("chalLo", puf_challenge[31:0], expChal[31:0]);
        checkOutput("chalHi", puf_challenge[127:96], expChal[127:96]);
        @(negedge clk);
        checkOutput("pufResetPulses", 32'(resetPulses - rpBase), expTo ? 32'd1 : 32'd0);

        spurious = (hold > 0);
        for (int k = 0; k < hold; k++) begin
            if (pokeStart && k == 3) begin
                start = 1'b1;
                reps  = 4'd5;
            end
            if (k == 4) start = 1'b0;
            @(negedge clk);
            checkOutput("holdValid", 32'(result_valid), 32'd1);
            checkOutput("holdResp", 32'(response), 32'(expResp));
            checkOutput("holdUnst", 32'(unstable), 32'(expUnst));
            checkOutput("holdTimeout", 32'(timeout), 32'(expTo));
        end
        spurious = 1'b0;
        start    = 1'b0;

        result_ready = 1'b1;
        if (pokeStart) begin
            start = 1'b1;
            reps  = 4'd3;
        end
        @(negedge clk);
        result_ready = 1'b0;
        start        = 1'b0;
        checkOutput("validCleared", 32'(result_valid), 32'd0);
        checkOutput("timeoutCleared", 32'(timeout), 32'd0);
        checkOutput("idleNotBusy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("noRestart", 32'(busy), 32'd0);
    endtask

    task automatic fillResponses(input logic [15:0] base);
        for (int k = 0; k < 16; k++) begin
            respList[k] = base ^ 16'($urandom & $urandom & $urandom);
        end
    endtask

    initial begin
        int r;
        int lim;
        logic [15:0] expR;
        logic [15:0] expU;

        reset        = 1'b1;
        start        = 1'b0;
        challenge    = '0;
        reps         = '0;
        result_ready = 1'b0;
        for (int k = 0; k < 16; k++) respList[k] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstValid", 32'(result_valid), 32'd0);
        checkOutput("rstResp", 32'(response), 32'd0);
        checkOutput("rstUnst", 32'(unstable), 32'd0);
        checkOutput("rstTimeout", 32'(timeout), 32'd0);
        checkOutput("rstTrig", 32'(puf_trigger), 32'd0);
        checkOutput("rstPufReset", 32'(puf_reset), 32'd0);
        checkOutput("rstChal", puf_challenge[31:0], 32'd0);

        respList[0] = 16'hA5C3;
        applyStimulus(1, 16, 99, 0, 1'b0);

        respList[0] = 16'hA5C3; respList[1] = 16'hA5C2; respList[2] = 16'hA5C3;
        refVote(3, expR, expU);
        checkOutput("refMaj3", 32'(expR), 32'h0000A5C3);
        applyStimulus(3, 5, 99, 0, 1'b0);

        respList[0] = 16'hA5C3; respList[1] = 16'hA5C3;
        respList[2] = 16'hA5C2; respList[3] = 16'hA5C2;
        applyStimulus(4, 3, 99, 0, 1'b0);

        applyStimulus(2, 4, 0, 0, 1'b0);

        fillResponses(16'h3C96);
        applyStimulus(2, 2, 99, 10, 1'b1);

        // reps=0 must be ignored entirely
        caseNum++;
        @(negedge clk);
        start = 1'b1;
        reps  = 4'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("repsZeroBusy", 32'(busy), 32'd0);
        checkOutput("repsZeroTrig", 32'(trigCount), 32'd0);

        // Reset during the second WAIT of a reps=5 run
        fillResponses(16'h5A5A);
        caseNum++;
        modelLat  = 10;
        doneLimit = 99;
        @(negedge clk);
        start     = 1'b1;
        reps      = 4'd5;
        challenge = {4{32'hDEADBEEF}};
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && trigCount < 2; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("rstReach", 32'(trigCount), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstValid", 32'(result_valid), 32'd0);
        checkOutput("midRstResp", 32'(response), 32'd0);
        checkOutput("midRstUnst", 32'(unstable), 32'd0);
        checkOutput("midRstTrig", 32'(puf_trigger), 32'd0);
        checkOutput("midRstChal", puf_challenge[31:0], 32'd0);
        fillResponses(16'h0FF0);
        applyStimulus(5, 6, 99, 0, 1'b0);

        for (int c = 0; c < 10; c++) begin
            r   = $urandom_range(1, 15);
            lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r - 1) : 99;
            fillResponses(16'($urandom));
            applyStimulus(r, $urandom_range(1, 6), lim, $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
